// File: rtl/epu_axil_csr_mc.sv
// ---------------------------------------------------------------------------
// epu_axil_csr_mc
//   AXI-Lite control/status block for NCH EPU GEMM engines. Each channel has
//   a KLEN register, a start strobe, a done latch, an error flag and a busy
//   cycle counter. There is also a global IRQ enable/status pair and an ID
//   register.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*   : AXI-Lite write (AW and W accepted independently)
//   s_ar*/s_r*        : AXI-Lite read
//   epu_start[c]      : one-cycle start pulse to engine c
//   epu_klen          : KLEN of channel c in bits [c*KW +: KW]
//   epu_done[c]       : one-cycle completion pulse from engine c
//   irq               : level interrupt, OR of (IRQ_EN & IRQ_STAT)
// ---------------------------------------------------------------------------
module epu_axil_csr_mc #(
    parameter int NCH    = 4,
    parameter int KMAX   = 1024,
    parameter int KW     = 11,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [31:0]       s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [NCH-1:0]    epu_start,
    output logic [NCH*KW-1:0] epu_klen,
    input  logic [NCH-1:0]    epu_done,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] A_IRQ_EN   = ADDR_W'(32'h100);
    localparam logic [ADDR_W-1:0] A_IRQ_STAT = ADDR_W'(32'h104);
    localparam logic [ADDR_W-1:0] A_ID       = ADDR_W'(32'h108);
    localparam logic [31:0]       ID_VAL     = 32'h4550_0200 | 32'(NCH);
    localparam logic [1:0]        RESP_OKAY  = 2'b00;
    localparam logic [1:0]        RESP_SLV   = 2'b10;

    // Write holding registers and response
    logic              aw_full_q, aw_full_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic              w_full_q, w_full_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    // Read side
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    // Per-channel and global state
    logic [NCH-1:0]    start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [NCH-1:0]    irq_en_q, irq_en_d, irq_stat_q, irq_stat_d;
    logic [KW-1:0]     klen_q [NCH];
    logic [KW-1:0]     klen_d [NCH];
    logic [CNT_W-1:0]  cyc_q  [NCH];
    logic [CNT_W-1:0]  cyc_d  [NCH];

    logic              wr_err, rd_err;
    logic [31:0]       klen_m, rd_data;
    logic [ADDR_W-1:0] ra;

    // Upper address bits are deliberately not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr[31:ADDR_W], s_araddr[31:ADDR_W]};

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Read decode straight from the AR address; captured on the handshake.
    always_comb begin
        ra      = s_araddr[ADDR_W-1:0];
        rd_data = '0;
        rd_err  = 1'b1;
        if (ra[ADDR_W-1:8] == '0) begin
            for (int c = 0; c < NCH; c++) begin
                if (32'(ra[7:5]) == c) begin
                    case (ra[4:0])
                        5'h00: rd_err = 1'b0;
                        5'h04: begin rd_err = 1'b0; rd_data = 32'(klen_q[c]); end
                        5'h08: begin rd_err = 1'b0; rd_data = {29'b0, err_q[c], done_q[c], busy_q[c]}; end
                        5'h0C: begin rd_err = 1'b0; rd_data = 32'(cyc_q[c]); end
                        default: ;
                    endcase
                end
            end
        end else begin
            case (ra)
                A_IRQ_EN:   begin rd_err = 1'b0; rd_data = 32'(irq_en_q); end
                A_IRQ_STAT: begin rd_err = 1'b0; rd_data = 32'(irq_stat_q); end
                A_ID:       begin rd_err = 1'b0; rd_data = ID_VAL; end
                default: ;
            endcase
        end
    end

    // NOTE: every variable written here gets a default first so no latch is inferred;
    // blocking assignments are correct in combinational logic.
    always_comb begin
        aw_full_d  = aw_full_q;
        aw_addr_d  = aw_addr_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        start_d    = '0;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        irq_en_d   = irq_en_q;
        irq_stat_d = irq_stat_q;
        klen_d     = klen_q;
        wr_err     = 1'b0;
        klen_m     = '0;

        // Saturating busy counters
        for (int c = 0; c < NCH; c++) begin
            if (busy_q[c] && cyc_q[c] != '1) cyc_d[c] = cyc_q[c] + CNT_W'(1);
            else                             cyc_d[c] = cyc_q[c];
        end

        if (s_awvalid && awready_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_awaddr[ADDR_W-1:0];
        end
        if (s_wvalid && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = s_wdata;
            w_strb_d = s_wstrb;
        end

        // Commit once both holders are full; bvalid rises with the effect.
        if (aw_full_q && w_full_q && !bvalid_q) begin
            bvalid_d = 1'b1;
            wr_err   = 1'b1;
            if (aw_addr_q[ADDR_W-1:8] == '0) begin
                for (int c = 0; c < NCH; c++) begin
                    if (32'(aw_addr_q[7:5]) == c) begin
                        wr_err = 1'b0;
                        case (aw_addr_q[4:0])
                            5'h00: begin
                                if (w_data_q[0] && w_strb_q[0]) begin
                                    if (busy_q[c]) wr_err = 1'b1;
                                    else begin
                                        start_d[c] = 1'b1;
                                        busy_d[c]  = 1'b1;
                                        done_d[c]  = 1'b0;
                                        cyc_d[c]   = '0;
                                    end
                                end
                            end
                            5'h04: begin
                                klen_m = apply_strb(32'(klen_q[c]), w_data_q, w_strb_q);
                                if (busy_q[c] || klen_m == '0 || klen_m > KMAX) wr_err = 1'b1;
                                else klen_d[c] = klen_m[KW-1:0];
                            end
                            5'h08: begin
                                if (w_strb_q[0] && w_data_q[1]) done_d[c] = 1'b0;
                                if (w_strb_q[0] && w_data_q[2]) err_d[c]  = 1'b0;
                            end
                            default: wr_err = 1'b1;  // CYCLES is read-only; rest unmapped
                        endcase
                        if (wr_err) err_d[c] = 1'b1;
                    end
                end
            end else begin
                case (aw_addr_q)
                    A_IRQ_EN: begin
                        wr_err = 1'b0;
                        if (w_strb_q[0]) irq_en_d = w_data_q[NCH-1:0];
                    end
                    A_IRQ_STAT: begin
                        wr_err = 1'b0;
                        if (w_strb_q[0]) irq_stat_d = irq_stat_q & ~w_data_q[NCH-1:0];
                    end
                    default: ;  // ID is read-only, everything else unmapped
                endcase
            end
            bresp_d = wr_err ? RESP_SLV : RESP_OKAY;
        end

        if (bvalid_q && s_bready) begin
            bvalid_d  = 1'b0;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end

        // Hardware completion is applied last so it overrides any W1C above.
        for (int c = 0; c < NCH; c++) begin
            if (epu_done[c]) begin
                done_d[c]     = 1'b1;
                irq_stat_d[c] = 1'b1;
                if (!start_d[c]) busy_d[c] = 1'b0;
            end
        end

        if (s_arvalid && arready_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_err ? RESP_SLV : RESP_OKAY;
        end
        if (rvalid_q && s_rready) rvalid_d = 1'b0;

        // Readies are registered so they are low during and right after reset.
        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d && !bvalid_d;
        arready_d = !rvalid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            start_q    <= '0;
            busy_q     <= '0;
            done_q     <= '0;
            err_q      <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            // NOTE: these small per-channel arrays are architectural registers with
            // defined reset values, so they are reset (unlike a RAM would be).
            for (int c = 0; c < NCH; c++) begin
                klen_q[c] <= KW'(1);
                cyc_q[c]  <= '0;
            end
        end else begin
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            klen_q     <= klen_d;
            cyc_q      <= cyc_d;
        end
    end

    always_comb begin
        epu_klen = '0;
        for (int c = 0; c < NCH; c++) epu_klen[c*KW +: KW] = klen_q[c];
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign epu_start = start_q;
    assign irq       = |(irq_en_q & irq_stat_q);

endmodule

// File: tb/tb_epu_axil_csr_mc.sv
// ---------------------------------------------------------------------------
// tb_epu_axil_csr_mc
//   Self-checking bench for epu_axil_csr_mc (NCH=4). Every AXI transaction
//   pushes its expected response onto a scoreboard queue; the entry is popped
//   and compared when the DUT returns the B or R beat.
// ---------------------------------------------------------------------------
module tb_epu_axil_csr_mc;
    localparam int NCH  = 4;
    localparam int KW   = 11;
    localparam int KMAX = 1024;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
    localparam logic [31:0] ID     = 32'h4550_0204;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       s_awaddr, s_wdata, s_araddr, s_rdata;
    logic              s_awvalid, s_awready, s_wvalid, s_wready;
    logic [3:0]        s_wstrb;
    logic [1:0]        s_bresp, s_rresp;
    logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NCH-1:0]    epu_start, epu_done;
    logic [NCH*KW-1:0] epu_klen;
    logic              irq;

    epu_axil_csr_mc #(.NCH(NCH), .KMAX(KMAX), .KW(KW), .ADDR_W(12), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .epu_start(epu_start), .epu_klen(epu_klen), .epu_done(epu_done), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;
    exp_t sb_q[$];

    // Start pulse monitor: total pulses and pulses longer than one cycle.
    int       start_cnt [NCH];
    int       wide_cnt  [NCH];
    logic [NCH-1:0] start_prev = '0;
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (epu_start[c]) start_cnt[c]++;
            if (epu_start[c] && start_prev[c]) wide_cnt[c]++;
        end
        start_prev = epu_start;
    end

    task automatic push_exp(input string tag, input logic [1:0] resp,
                            input logic [31:0] data, input logic [31:0] mask);
        exp_t e;
        e.tag = tag; e.resp = resp; e.data = data; e.mask = mask;
        sb_q.push_back(e);
    endtask

    // Waits for the B beat, optionally holding bready low, then scores it.
    task automatic wait_b(input int bhold);
        exp_t e;
        int   cyc = 0;
        @(negedge clk);
        while (!s_bvalid && cyc < 100) begin @(negedge clk); cyc++; end
        if (sb_q.size() == 0) begin check("sb_empty_b", 0, 1); return; end
        e = sb_q.pop_front();
        if (!s_bvalid) begin check({e.tag, "_b_timeout"}, 0, 1); s_bready = 1'b1; return; end
        for (int i = 0; i < bhold; i++) begin
            check({e.tag, "_bp_bvalid"}, s_bvalid, 1);
            check({e.tag, "_bp_rdy"}, {s_awready, s_wready}, 2'b00);
            @(negedge clk);
        end
        s_bready = 1'b1;
        check({e.tag, "_bresp"}, s_bresp, e.resp);
        @(posedge clk); #1;
    endtask

    task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp, input int lead, input int bhold,
                          input string tag);
        int cyc = 0;
        bit aw_hs, w_hs, aw_done = 0, w_done = 0;
        push_exp(tag, exp_resp, 32'h0, 32'h0);
        s_bready  = (bhold == 0);
        s_awaddr  = addr;
        s_wdata   = data;
        s_wstrb   = strb;
        s_wvalid  = 1'b1;
        s_awvalid = (lead == 0);
        while (!(aw_done && w_done) && cyc < 100) begin
            @(negedge clk);
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin s_wvalid  = 1'b0; w_done  = 1; end
            if (!aw_done && cyc >= lead) s_awvalid = 1'b1;
        end
        if (!(aw_done && w_done)) begin
            check({tag, "_aw_w_timeout"}, 0, 1);
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
        end
        wait_b(bhold);
    endtask

    task automatic axi_rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic [31:0] mask,
                          input logic [1:0] exp_resp, input int rhold, input string tag);
        exp_t e;
        int   cyc = 0;
        push_exp(tag, exp_resp, exp_data, mask);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        s_rready  = (rhold == 0);
        @(negedge clk);
        while (!s_arready && cyc < 100) begin @(negedge clk); cyc++; end
        if (!s_arready) check({tag, "_ar_timeout"}, 0, 1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!s_rvalid && cyc < 100) begin @(negedge clk); cyc++; end
        e = sb_q.pop_front();
        if (!s_rvalid) begin check({e.tag, "_r_timeout"}, 0, 1); s_rready = 1'b1; return; end
        for (int i = 0; i < rhold; i++) begin
            check({e.tag, "_hold_rdata"}, {s_rvalid, s_rdata & e.mask}, {1'b1, e.data});
            @(negedge clk);
        end
        s_rready = 1'b1;
        check({e.tag, "_rdata"}, s_rdata & e.mask, e.data);
        check({e.tag, "_rresp"}, s_rresp, e.resp);
        @(posedge clk); #1;
    endtask

    task automatic pulse_done(input int c);
        epu_done[c] = 1'b1;
        @(posedge clk); #1;
        epu_done[c] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b1;
        epu_done = '0;
        repeat (5) @(posedge clk);
        #1;
        // Reset state
        check("rst_ready", {s_awready, s_wready, s_arready}, 3'b000);
        check("rst_valid", {s_bvalid, s_rvalid}, 2'b00);
        check("rst_resp_data", {s_bresp, s_rresp, s_rdata}, 36'h0);
        check("rst_start_irq", {epu_start, irq}, 5'h0);
        check("rst_klen", epu_klen, {NCH{11'd1}});
        rst = 1'b0;
        @(posedge clk); #1;

        axi_rd(32'h108, ID, '1, OKAY, 0, "id");
        axi_rd(32'h008, 32'h0, '1, OKAY, 0, "status0_rst");
        axi_rd(32'h004, 32'h1, '1, OKAY, 0, "klen0_rst");
        check("irq_rst", irq, 1'b0);

        // Decoupled write: W three cycles ahead of AW
        axi_wr(32'h024, 32'd4, 4'hF, OKAY, 3, 0, "klen1_wr");
        axi_rd(32'h024, 32'd4, '1, OKAY, 0, "klen1_rd");
        check("klen1_port", epu_klen[1*KW +: KW], 11'd4);

        // CTRL start without wstrb[0] does nothing
        axi_wr(32'h000, 32'h1, 4'h2, OKAY, 0, 0, "ctrl_nostrb");
        check("ctrl_nostrb_pulse", start_cnt[0], 0);

        // Start / done on channel 2 with interrupt
        axi_wr(32'h100, 32'h4, 4'hF, OKAY, 0, 0, "irq_en");
        axi_wr(32'h040, 32'h1, 4'hF, OKAY, 0, 0, "start2");
        @(posedge clk); #1;
        check("start2_pulse", {start_cnt[2], wide_cnt[2]}, {32'd1, 32'd0});
        axi_rd(32'h048, 32'h1, '1, OKAY, 0, "status2_busy");
        repeat (90) @(posedge clk);
        #1;
        pulse_done(2);
        axi_rd(32'h048, 32'h2, '1, OKAY, 0, "status2_done");
        // Roughly 100 busy cycles: anywhere in 64..127
        axi_rd(32'h04C, 32'h40, 32'hFFFF_FFC0, OKAY, 0, "cycles2");
        check("irq_set", irq, 1'b1);
        axi_rd(32'h104, 32'h4, '1, OKAY, 0, "irq_stat_set");
        axi_wr(32'h104, 32'h4, 4'hF, OKAY, 0, 0, "irq_w1c");
        check("irq_clr", irq, 1'b0);
        axi_rd(32'h104, 32'h0, '1, OKAY, 0, "irq_stat_clr");

        // Illegal KLEN values
        axi_wr(32'h024, 32'd0, 4'hF, SLVERR, 0, 0, "klen_zero");
        axi_wr(32'h024, 32'd1025, 4'hF, SLVERR, 0, 0, "klen_1025");
        axi_rd(32'h024, 32'd4, '1, OKAY, 0, "klen1_kept");
        axi_rd(32'h028, 32'h4, '1, OKAY, 0, "status1_err");
        axi_wr(32'h028, 32'h4, 4'hF, OKAY, 0, 0, "err_w1c");
        axi_rd(32'h028, 32'h0, '1, OKAY, 0, "status1_clr");

        // KMAX boundary and partial strobes
        axi_wr(32'h004, 32'd1024, 4'hF, OKAY, 0, 0, "klen0_kmax");
        axi_rd(32'h004, 32'd1024, '1, OKAY, 0, "klen0_kmax_rd");
        check("klen0_port", epu_klen[0 +: KW], 11'd1024);
        axi_wr(32'h024, 32'h0000_0300, 4'b0010, OKAY, 0, 0, "klen1_strb");
        axi_rd(32'h024, 32'h304, '1, OKAY, 0, "klen1_strb_rd");

        // Start and KLEN write while busy
        axi_wr(32'h060, 32'h1, 4'hF, OKAY, 0, 0, "start3");
        axi_wr(32'h060, 32'h1, 4'hF, SLVERR, 0, 0, "start3_busy");
        @(posedge clk); #1;
        check("start3_pulses", start_cnt[3], 1);
        axi_wr(32'h064, 32'd5, 4'hF, SLVERR, 0, 0, "klen3_busy");
        axi_rd(32'h068, 32'h5, '1, OKAY, 0, "status3_busy_err");
        pulse_done(3);
        axi_rd(32'h068, 32'h6, '1, OKAY, 0, "status3_done_err");

        // Unmapped and read-only
        axi_rd(32'h0A0, 32'h0, '1, SLVERR, 0, "rd_ch5");
        axi_wr(32'h10C, 32'h0, 4'hF, SLVERR, 0, 0, "wr_unmapped");
        axi_wr(32'h108, 32'h0, 4'hF, SLVERR, 0, 0, "id_ro");
        axi_wr(32'h00C, 32'h0, 4'hF, SLVERR, 0, 0, "cycles_ro");
        axi_rd(32'h008, 32'h4, '1, OKAY, 0, "status0_err");
        axi_rd(32'h1000_0108, ID, '1, OKAY, 0, "id_upper_bits");

        // Backpressure on B and R
        axi_wr(32'h100, 32'h4, 4'hF, OKAY, 0, 10, "bp_wr");
        axi_rd(32'h108, ID, '1, OKAY, 5, "bp_rd");

        // Collision: IRQ_STAT[0] W1C commits in the same cycle as epu_done[0]
        pulse_done(0);
        axi_rd(32'h104, 32'h9, '1, OKAY, 0, "irq_stat_pre");
        push_exp("coll_w1c", OKAY, 32'h0, 32'h0);
        check("coll_rdy", {s_awready, s_wready}, 2'b11);
        s_awaddr = 32'h104; s_wdata = 32'h1; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(posedge clk); #1;               // both beats accepted
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        epu_done[0] = 1'b1;
        @(posedge clk); #1;               // commit edge
        epu_done[0] = 1'b0;
        wait_b(0);
        axi_rd(32'h104, 32'h9, '1, OKAY, 0, "coll_irq_stat");
        axi_rd(32'h008, 32'h6, '1, OKAY, 0, "coll_status0");
        axi_wr(32'h104, 32'h1, 4'hF, OKAY, 0, 0, "w1c_after");
        axi_rd(32'h104, 32'h8, '1, OKAY, 0, "irq_stat_after");

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end
endmodule
